neg_stream: RTL and testbench
=============================

Name: neg_stream

Overview:
- Multi-precision two's complement negator for operands wider than one datapath word.
- Operands arrive as a valid/ready stream of `width`-bit words, least significant word first, with `last` marking the most significant word.
- Computes Z = -A over the whole multi-word operand and emits it word-by-word on an output stream.
- Per-word core is the codebase's parallel-prefix word negator, whose carry-in is driven by a cross-beat carry register.
- Sits between the operand fetch stage and the multi-precision adder/accumulator pipeline.

Parameters:
- width, 8, word width in bits (>= 2).
- speed, 0, prefix structure selector passed to the per-word negate/prefix logic (0 serial, 1 Brent-Kung, 2 Sklansky); affects timing only, never function.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  block accepts input word this cycle.
- in_data_i  input  width  operand word (LSW first).
- in_last_i  input  1  word is the most significant word of the operand.
- out_valid_o  output  1  output word valid.
- out_ready_i  input  1  downstream accepts output word.
- out_data_o  output  width  result word.
- out_last_o  output  1  result word is the MSW.
- out_zero_o  output  1  valid only with out_last_o: whole operand was zero.
- out_ovf_o  output  1  valid only with out_last_o: operand was the most negative value (-A not representable; result equals A).

Behaviour:
- Word arithmetic:
  - Accepted word W with carry state c gives R = (~W + c) mod 2^width.
  - c=1: R is the word two's complement of W, via the prefix negator.
  - c=0: R = ~W.
- Carry register carry_q:
  - Reset value 1.
  - On each accepted non-last word: carry_q <= carry_q & (W == 0).
  - On an accepted last word: carry_q <= 1, ready for the next operand.
- Flags, computed on the last word:
  - zero = carry_q & (W == 0).
  - ovf = carry_q & (W == {1'b1, {width-1{1'b0}}}).
  - Both are 0 on non-last beats.
  - Single-word operands: carry_q is 1, so the flags reduce to W==0 and W==MSB-only.
- Pipeline: one output register stage; latency 1 cycle from input handshake to out_valid_o.
- Handshake:
  - in_ready_o = !out_valid_o | out_ready_i, combinational.
  - Accept when in_valid_i & in_ready_o; the output register loads R, last, zero and ovf on the next edge and sets out_valid_o.
  - Output accepted (out_ready_i high) with no new input: out_valid_o clears.
  - Simultaneous output accept and input accept: register reloads; out_valid_o stays 1; full throughput of one word per cycle.
  - out_valid_o high and out_ready_i low: out_data_o, out_last_o, out_zero_o and out_ovf_o hold stable and in_ready_o is 0.
- Input protocol: once in_valid_i rises it stays high and its data stable until accepted; the block does not check this.
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, out_zero_o=0, out_ovf_o=0, carry_q=1.
- Reset mid-operand: partial operand is discarded, carry_q returns to 1, and the next accepted word is treated as an LSW.
- Output data is not gated: out_data_o holds the last loaded value when out_valid_o is 0.
- No internal word count limit; operands of any length are handled by carry_q alone.

Test Plan:
- width=8, operand 0x1234 as words 0x34, 0x12(last), out_ready_i=1 -> outputs 0xCC then 0xED(last); zero=0, ovf=0; out_valid_o 1 cycle after each accept.
- Operand 0x0100 (0x00, 0x01 last) -> 0x00, 0xFF(last); carry stays 1 through the zero LSW.
- Operand 0x0000 (0x00, 0x00 last) -> 0x00, 0x00(last) with out_zero_o=1; single word 0x80(last) -> 0x80 with out_ovf_o=1; operand 0x8000 -> 0x00, 0x80 with out_ovf_o=1.
- Back-to-back operands 0x01(last) then 0xFF, 0xFF(last) at full rate -> 0xFF(last), then 0x01, 0x00(last); carry re-arms after each last.
- Backpressure: hold out_ready_i=0 for 3 cycles with a word pending -> out_* stable and in_ready_o=0 throughout; release -> next word accepted in the same cycle.
- Assert rst_ni low after accepting LSW 0x00 of a 2-word operand -> out_valid_o=0 immediately; after release, single word 0x05(last) -> 0xFB, proving carry_q=1.

Source files
------------

// File: rtl/neg_stream.sv
// Streaming multi-precision two's complement negator.
// Operands arrive LSW first. The per-word core computes ~W + c, where c is a carry
// held across beats. The result leaves through a single registered output stage.
module neg_stream #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_zero_o,
  output logic             out_ovf_o
);

  localparam int W = int'(width);
  localparam int Levels = (width > 1) ? $clog2(width) : 1;
  localparam logic [width-1:0] MsbOnly = {1'b1, {(width-1){1'b0}}};

  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ovf_q, out_ovf_d;

  logic [width-1:0] zpre;    // zpre[i]: in_data_i[i:0] is all zero
  logic [width-1:0] cin;     // carry into each bit of ~W + carry_q
  logic [width-1:0] word_res;
  logic             word_zero;
  logic             word_msb;
  logic             accept;

  // Prefix AND over the inverted word; the structure only changes timing.
  always_comb begin
    zpre = ~in_data_i;
    case (speed)
      1: begin
        // Brent-Kung: up-sweep, then down-sweep fills the gaps.
        for (int l = 0; l < Levels; l++) begin
          for (int i = (2 << l) - 1; i < W; i += (2 << l)) begin
            zpre[i] = zpre[i] & zpre[i - (1 << l)];
          end
        end
        for (int l = Levels - 2; l >= 0; l--) begin
          for (int i = 3 * (1 << l) - 1; i < W; i += (2 << l)) begin
            zpre[i] = zpre[i] & zpre[i - (1 << l)];
          end
        end
      end
      2: begin
        // Sklansky: at level l, every bit with bit l of its index set takes the
        // prefix that ends just below its 2^l-aligned block.
        for (int l = 0; l < Levels; l++) begin
          for (int i = 0; i < W; i++) begin
            if (((i >> l) & 1) == 1) begin
              zpre[i] = zpre[i] & zpre[((i >> l) << l) - 1];
            end
          end
        end
      end
      default: begin
        for (int i = 1; i < W; i++) begin
          zpre[i] = zpre[i] & zpre[i - 1];
        end
      end
    endcase
  end

  // Word negate: bit i flips relative to ~W iff carry_q and all lower bits of W are zero.
  always_comb begin
    cin       = {zpre[width-2:0], 1'b1} & {width{carry_q}};
    word_res  = ~in_data_i ^ cin;
    word_zero = zpre[width-1];
    word_msb  = (in_data_i == MsbOnly);
  end

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  // Next-state for the output stage and the cross-beat carry.
  always_comb begin
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = word_res;
      out_last_d  = in_last_i;
      out_zero_d  = in_last_i & carry_q & word_zero;
      out_ovf_d   = in_last_i & carry_q & word_msb;
      // Re-arm on the MSW so the next word starts a fresh operand.
      carry_d     = in_last_i ? 1'b1 : (carry_q & word_zero);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      carry_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_zero_o  = out_zero_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_neg_stream.sv
// Directed bench for neg_stream (width 8): hand-computed vectors, immediate assertions.
module tb_neg_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_zero;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  neg_stream #(
    .width(8),
    .speed(0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_zero_o (out_zero),
    .out_ovf_o  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word, expect acceptance, then check the registered result.
  task automatic beat(input string tag, input logic [7:0] d, input logic l,
                      input logic [7:0] ed, input logic el, input logic ez, input logic eo);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " data"}, {24'd0, out_data}, {24'd0, ed});
    chk({tag, " last"}, {31'd0, out_last}, {31'd0, el});
    chk({tag, " zero"}, {31'd0, out_zero}, {31'd0, ez});
    chk({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, eo});
  endtask

  task automatic idle(input string tag, input logic [7:0] held);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " valid clr"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " data held"}, {24'd0, out_data}, {24'd0, held});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst data", {24'd0, out_data}, 32'd0);
    chk("rst last", {31'd0, out_last}, 32'd0);
    chk("rst zero", {31'd0, out_zero}, 32'd0);
    chk("rst ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // -0x1234 = 0xEDCC
    beat("1234 w0", 8'h34, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0);
    beat("1234 w1", 8'h12, 1'b1, 8'hED, 1'b1, 1'b0, 1'b0);
    idle("1234 idle", 8'hED);

    // -0x0100 = 0xFF00, carry survives the zero LSW
    beat("0100 w0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("0100 w1", 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // zero operand
    beat("0000 w0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("0000 w1", 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    // most negative single word and two-word values
    beat("80 w0", 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    beat("8000 w0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("8000 w1", 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);

    // MSB-only pattern above a nonzero LSW: no overflow, result ~W
    beat("8001 w0", 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("8001 w1", 8'h80, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);

    // back-to-back operands at full rate: -0x01, then -0xFFFF = 0x0001
    beat("b2b a", 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    beat("b2b b0", 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    beat("b2b b1", 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    idle("b2b idle", 8'h00);

    // backpressure: result 0xFD held while 0x07 waits
    out_ready = 1'b0;
    beat("bp w0", 8'h03, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h07;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp valid", {31'd0, out_valid}, 32'd1);
      chk("bp data", {24'd0, out_data}, 32'h0000_00FD);
      chk("bp last", {31'd0, out_last}, 32'd1);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp next valid", {31'd0, out_valid}, 32'd1);
    chk("bp next data", {24'd0, out_data}, 32'h0000_00F9);
    chk("bp next last", {31'd0, out_last}, 32'd1);
    idle("bp idle", 8'hF9);

    // reset after a zero LSW
    beat("rst0 w0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst0 valid", {31'd0, out_valid}, 32'd0);
    chk("rst0 data", {24'd0, out_data}, 32'd0);
    #3;
    rst_n = 1'b1;
    beat("rst0 05", 8'h05, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0);

    // reset after a nonzero LSW clears carry; without reset 0x05 would give 0xFA
    beat("rst1 w0", 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst1 valid", {31'd0, out_valid}, 32'd0);
    #3;
    rst_n = 1'b1;
    beat("rst1 05", 8'h05, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0);
    idle("end idle", 8'hFB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
